// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, divider states and the core state that launches a divide.
// Optional build macro used by the divider: DIV_ZERO_FASTPATH_EN.
package alu_pkg;

    localparam int DATA_BITS = 8;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ADD = 2'b00;
    localparam alu_op_t SUB = 2'b01;
    localparam alu_op_t MUL = 2'b10;
    localparam alu_op_t DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam logic [2:0] CORE_EXECUTE = 3'b101;

endpackage

// File: rtl/alu_div_scheduler_if.sv
// Request/result bundle between the thread ALUs (master) and the shared divider (slave).
interface alu_div_scheduler_if #(
    parameter int N         = 4,
    parameter int DATA_BITS = 8
);
    logic [N-1:0]           req;
    logic [N*DATA_BITS-1:0] rs_flat;
    logic [N*DATA_BITS-1:0] rt_flat;
    logic [N-1:0]           done;
    logic [DATA_BITS-1:0]   quotient;
    logic [DATA_BITS-1:0]   remainder;
    logic                   busy;
    logic [$clog2(N)-1:0]   grant_id;

    modport master (
        output req, rs_flat, rt_flat,
        input  done, quotient, remainder, busy, grant_id
    );

    modport slave (
        input  req, rs_flat, rt_flat,
        output done, quotient, remainder, busy, grant_id
    );
endinterface

// File: rtl/alu_div_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] sel,
    output logic         valid
);

    logic [W-1:0] idx_s;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        sel   = '0;
        idx_s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = W'((int'(ptr) + k) % N);
            if (req[idx_s]) begin
                valid = 1'b1;
                sel   = idx_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/alu_div_scheduler.sv
// Shared restoring divider with round-robin grant among thread ALUs.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor goes straight from grant to DONE.
module alu_div_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_div_scheduler_if.slave   bus
);
    import alu_pkg::*;

    localparam int N  = THREADS_PER_BLOCK;
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(DATA_BITS);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]           state_r;
    logic [W-1:0]         ptr_r;
    logic [W-1:0]         grant_r;
    logic [CW-1:0]        cnt_r;
    logic [DATA_BITS-1:0] dvd_r;
    logic [DATA_BITS-1:0] dvs_r;
    logic [DATA_BITS-1:0] rem_r;
    logic [DATA_BITS-1:0] quo_r;
    logic [N-1:0]         done_r;
    logic [DATA_BITS-1:0] quo_out_r;
    logic [DATA_BITS-1:0] rem_out_r;
    logic                 busy_r;

    logic [W-1:0]         sel_s;
    logic                 valid_s;
    logic [DATA_BITS-1:0] rs_sel_s;
    logic [DATA_BITS-1:0] rt_sel_s;
    logic [DATA_BITS:0]   rem_ext_s;
    logic [DATA_BITS-1:0] diff_s;
    logic                 ge_s;

    rr_arbiter #(.N(N), .W(W)) u_arb (
        .req   (bus.req),
        .ptr   (ptr_r),
        .sel   (sel_s),
        .valid (valid_s)
    );

    // Operand mux for the thread the arbiter picked.
    always_comb begin
        rs_sel_s = '0;
        rt_sel_s = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_s == W'(i)) begin
                rs_sel_s = bus.rs_flat[i*DATA_BITS +: DATA_BITS];
                rt_sel_s = bus.rt_flat[i*DATA_BITS +: DATA_BITS];
            end else begin
                rs_sel_s = rs_sel_s;
            end
        end
    end

    // One restoring step; the extra top bit keeps divisors above 2^(DATA_BITS-1) correct.
    always_comb begin
        rem_ext_s = {rem_r, dvd_r[DATA_BITS-1]};
        ge_s      = (rem_ext_s >= {1'b0, dvs_r});
        diff_s    = rem_ext_s[DATA_BITS-1:0] - dvs_r;
    end

    // Scheduler FSM, datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            grant_r   <= '0;
            cnt_r     <= '0;
            dvd_r     <= '0;
            dvs_r     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            done_r    <= '0;
            quo_out_r <= '0;
            rem_out_r <= '0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_s) begin
                        grant_r <= sel_s;
                        dvd_r   <= rs_sel_s;
                        dvs_r   <= rt_sel_s;
                        rem_r   <= '0;
                        quo_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
                        if (rt_sel_s == '0) begin
                            quo_r   <= '1;
                            rem_r   <= rs_sel_s;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_BUSY;
                        end
`else
                        state_r <= ST_BUSY;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    rem_r <= ge_s ? diff_s : rem_ext_s[DATA_BITS-1:0];
                    quo_r <= {quo_r[DATA_BITS-2:0], ge_s};
                    dvd_r <= {dvd_r[DATA_BITS-2:0], 1'b0};
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(DATA_BITS - 1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    done_r    <= {{(N-1){1'b0}}, 1'b1} << grant_r;
                    quo_out_r <= quo_r;
                    rem_out_r <= rem_r;
                    busy_r    <= 1'b0;
                    ptr_r     <= (grant_r == W'(N - 1)) ? '0 : grant_r + W'(1);
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done      = done_r;
    assign bus.quotient  = quo_out_r;
    assign bus.remainder = rem_out_r;
    assign bus.busy      = busy_r;
    assign bus.grant_id  = grant_r;

endmodule

// File: tb/tb_alu_div_scheduler.sv
// Directed bench for alu_div_scheduler: vector table plus arbitration/reset/operand-hold sequences.
module tb_alu_div_scheduler;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    alu_div_scheduler_if #(.N(4), .DATA_BITS(8)) bus_i ();

    alu_div_scheduler #(.THREADS_PER_BLOCK(4), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       thr;
        bit [7:0] rs;
        bit [7:0] rt;
        bit [7:0] q;
        bit [7:0] r;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus_i.done == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(bus_i.done != 4'b0000), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
    endtask

    vec_t vecs[10];
    int   n;
    int   lat;
    int   exp_lat;
    int   ord_a[3];
    int   ord_b[5];
    bit [7:0] qa[4];
    bit [7:0] ra[4];

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b0;
        bus_i.req = 4'b0000;
        bus_i.rs_flat = 32'd0;
        bus_i.rt_flat = 32'd0;

        vecs[0] = '{1, 8'd100, 8'd7,   8'd14,  8'd2};
        vecs[1] = '{0, 8'd50,  8'd5,   8'd10,  8'd0};
        vecs[2] = '{2, 8'd255, 8'd16,  8'd15,  8'd15};
        vecs[3] = '{3, 8'd9,   8'd0,   8'd255, 8'd9};
        vecs[4] = '{0, 8'd200, 8'd3,   8'd66,  8'd2};
        vecs[5] = '{2, 8'd0,   8'd5,   8'd0,   8'd0};
        vecs[6] = '{1, 8'd255, 8'd255, 8'd1,   8'd0};
        vecs[7] = '{3, 8'd7,   8'd200, 8'd0,   8'd7};
        vecs[8] = '{1, 8'd128, 8'd1,   8'd128, 8'd0};
        vecs[9] = '{0, 8'd255, 8'd1,   8'd255, 8'd0};

        do_reset();
        check("rst_done",  32'(bus_i.done), 32'd0);
        check("rst_busy",  32'(bus_i.busy), 32'd0);
        check("rst_grant", 32'(bus_i.grant_id), 32'd0);
        check("rst_quot",  32'(bus_i.quotient), 32'd0);
        check("rst_rem",   32'(bus_i.remainder), 32'd0);
        reset = 1'b1;
        tick();

        foreach (vecs[v]) begin
            bus_i.rs_flat = 32'd0;
            bus_i.rt_flat = 32'd0;
            bus_i.rs_flat[vecs[v].thr*8 +: 8] = vecs[v].rs;
            bus_i.rt_flat[vecs[v].thr*8 +: 8] = vecs[v].rt;
            bus_i.req = 4'b0000;
            bus_i.req[vecs[v].thr] = 1'b1;
            tick();
            check("vec_busy",  32'(bus_i.busy), 32'd1);
            check("vec_grant", 32'(bus_i.grant_id), 32'(vecs[v].thr));
            wait_done(n);
            lat = n + 1;
            exp_lat = 10;
`ifdef DIV_ZERO_FASTPATH_EN
            if (vecs[v].rt == 8'd0) exp_lat = 2;
`endif
            check("vec_latency", 32'(lat), 32'(exp_lat));
            check("vec_done",  32'(bus_i.done), 32'd1 << vecs[v].thr);
            check("vec_quot",  32'(bus_i.quotient), 32'(vecs[v].q));
            check("vec_rem",   32'(bus_i.remainder), 32'(vecs[v].r));
            bus_i.req = 4'b0000;
            tick();
            check("vec_pulse", 32'(bus_i.done), 32'd0);
            check("vec_idle_busy", 32'(bus_i.busy), 32'd0);
        end

        // Threads 0 and 2 held from reset release: order 0, 2, 0.
        bus_i.req = 4'b0000;
        do_reset();
        bus_i.rs_flat = {8'd0, 8'd255, 8'd0, 8'd50};
        bus_i.rt_flat = {8'd0, 8'd16,  8'd0, 8'd5};
        qa = '{8'd10, 8'd0, 8'd15, 8'd0};
        ra = '{8'd0,  8'd0, 8'd15, 8'd0};
        ord_a = '{0, 2, 0};
        bus_i.req = 4'b0101;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(n);
            check("rrA_done", 32'(bus_i.done), 32'd1 << ord_a[k]);
            check("rrA_quot", 32'(bus_i.quotient), 32'(qa[ord_a[k]]));
            check("rrA_rem",  32'(bus_i.remainder), 32'(ra[ord_a[k]]));
            tick();
            check("rrA_pulse", 32'(bus_i.done), 32'd0);
        end

        // All four requesting continuously: order 0,1,2,3,0.
        bus_i.req = 4'b0000;
        do_reset();
        bus_i.rs_flat = {8'd41, 8'd31, 8'd21, 8'd11};
        bus_i.rt_flat = {8'd5,  8'd4,  8'd3,  8'd2};
        qa = '{8'd5, 8'd7, 8'd7, 8'd8};
        ra = '{8'd1, 8'd0, 8'd3, 8'd1};
        ord_b = '{0, 1, 2, 3, 0};
        bus_i.req = 4'b1111;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_done(n);
            check("rrB_done", 32'(bus_i.done), 32'd1 << ord_b[k]);
            check("rrB_quot", 32'(bus_i.quotient), 32'(qa[ord_b[k]]));
            check("rrB_rem",  32'(bus_i.remainder), 32'(ra[ord_b[k]]));
            tick();
            check("rrB_pulse", 32'(bus_i.done), 32'd0);
        end

        // Reset in the 4th BUSY cycle abandons the op; re-request runs at full latency.
        bus_i.req = 4'b0000;
        do_reset();
        reset = 1'b1;
        bus_i.rs_flat = {8'd0, 8'd0, 8'd200, 8'd0};
        bus_i.rt_flat = {8'd0, 8'd0, 8'd3,   8'd0};
        bus_i.req = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        check("mid_busy_pre", 32'(bus_i.busy), 32'd1);
        reset = 1'b0;
        tick();
        check("mid_rst_busy", 32'(bus_i.busy), 32'd0);
        check("mid_rst_done", 32'(bus_i.done), 32'd0);
        reset = 1'b1;
        wait_done(n);
        check("rereq_latency", 32'(n), 32'd10);
        check("rereq_done", 32'(bus_i.done), 32'b0010);
        check("rereq_quot", 32'(bus_i.quotient), 32'd66);
        check("rereq_rem",  32'(bus_i.remainder), 32'd2);
        bus_i.req = 4'b0000;
        tick();

        // req[3] dropped and operands changed mid-BUSY: latched operands win.
        bus_i.rs_flat = {8'd100, 8'd0, 8'd0, 8'd0};
        bus_i.rt_flat = {8'd7,   8'd0, 8'd0, 8'd0};
        bus_i.req = 4'b1000;
        tick();
        check("hold_grant", 32'(bus_i.grant_id), 32'd3);
        tick();
        tick();
        bus_i.req = 4'b0000;
        bus_i.rs_flat = {8'd3, 8'd0, 8'd0, 8'd0};
        bus_i.rt_flat = {8'd1, 8'd0, 8'd0, 8'd0};
        wait_done(n);
        check("hold_done", 32'(bus_i.done), 32'b1000);
        check("hold_quot", 32'(bus_i.quotient), 32'd14);
        check("hold_rem",  32'(bus_i.remainder), 32'd2);
        tick();
        check("hold_pulse", 32'(bus_i.done), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
